// File: rtl/rsa_packet_tx.sv
// RSA result packet transmitter: header then payload, MSB byte first,
// each byte sent as an 8N1 UART frame at BAUD_RATE.
module rsa_packet_tx #(
  parameter int CLOCK_FREQ   = 100_000_000,
  parameter int BAUD_RATE    = 12_000_000,
  parameter int HEADER_SIZE  = 32,
  parameter int MESSAGE_SIZE = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [HEADER_SIZE-1:0]  header_in,
  input  logic [MESSAGE_SIZE-1:0] data_in,
  input  logic                    valid_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    uart_txd
);

  localparam int BAUD_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int PW          = HEADER_SIZE + MESSAGE_SIZE;
  localparam int NBYTES      = PW / 8;
  localparam int BW          = $clog2(BAUD_PERIOD);
  localparam int YW          = $clog2(NBYTES);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_PERIOD - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [YW-1:0]   byte_q, byte_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            tick;
  logic [7:0]      cur_byte;

  assign tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          shreg_d = {header_in, data_in};
          state_d = START;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 1'b1;
            shreg_d = shreg_q << 8;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so uart_txd stays registered.
  assign cur_byte = shreg_d[PW-1 -: 8];

  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign busy_out = (state_q != IDLE);
  assign done_out = done_q;
  assign uart_txd = txd_q;

endmodule

// File: doc/rsa_packet_tx.md
Name: rsa_packet_tx

Overview:
- Serializes one RSA result packet onto the board UART TX line.
- A packet is a HEADER_SIZE-bit header followed by a MESSAGE_SIZE-bit payload, typically ciphertext or plaintext from mod_exponent.
- Each byte is framed as 8N1 and driven at BAUD_RATE.
- This block is the transmit end of the host link whose receive side feeds messages into the crypto pipeline.

Parameters:
- CLOCK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 12_000_000: UART bit rate.
- BAUD_PERIOD is derived as CLOCK_FREQ/BAUD_RATE, truncated. With the defaults it is 8 cycles per bit. BAUD_PERIOD must be at least 2.
- HEADER_SIZE, 32: header width in bits. Must be a multiple of 8 and at least 8.
- MESSAGE_SIZE, 64: payload width in bits. Must be a multiple of 8 and at least 8.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- header_in  input  HEADER_SIZE  packet header; sampled on acceptance.
- data_in  input  MESSAGE_SIZE  packet payload; sampled on acceptance.
- valid_in  input  1  request to send one packet.
- busy_out  output  1  high while a packet is in flight.
- done_out  output  1  one-cycle pulse when the last stop bit completes.
- uart_txd  output  1  serial line; idle level is high.

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: uart_txd=1, busy_out=0, done_out=0. All internal counters are 0 and the FSM is in IDLE.
- Reset has priority over everything. Asserting rst_in mid-packet returns the block to IDLE on that edge: uart_txd=1 next cycle, and no done_out pulse.
- Acceptance: on a rising edge where state=IDLE and valid_in=1:
  - {header_in, data_in} is latched into a (HEADER_SIZE+MESSAGE_SIZE)-bit shift register.
  - busy_out goes 1 on that same edge.
  - valid_in while busy_out=1 is ignored; nothing is queued.
- Byte order:
  - Header first, most-significant byte first.
  - Then payload, most-significant byte first.
  - Total NBYTES = (HEADER_SIZE+MESSAGE_SIZE)/8.
- Bit order within a byte: LSB first.
- Byte frame: start bit (0), then 8 data bits, then 1 stop bit (1). Each bit is held for exactly BAUD_PERIOD cycles. Bytes are back-to-back with no extra idle gap.
- FSM states:
  - IDLE → START on acceptance.
  - START → DATA after BAUD_PERIOD cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → START after BAUD_PERIOD cycles if bytes remain.
  - STOP → IDLE after BAUD_PERIOD cycles on the last byte.
- Counters:
  - Baud counter runs 0..BAUD_PERIOD-1 and wraps; it advances the bit on wrap.
  - Bit index runs 0..7.
  - Byte counter runs 0..NBYTES-1.
- uart_txd is registered. It shows the start bit in the cycle immediately after the acceptance edge.
- Latency: the first start bit appears 1 cycle after acceptance. A packet occupies exactly NBYTES*10*BAUD_PERIOD cycles of line time. With defaults that is 12*10*8 = 960 cycles.
- Completion: on the edge that ends the final stop-bit period:
  - busy_out→0 and done_out→1 together.
  - done_out is 1 for exactly one cycle.
  - uart_txd stays 1.
- Back-to-back: valid_in=1 in the cycle done_out=1 is accepted (state is IDLE). The next start bit follows one cycle later, so the idle gap between packets is 1 cycle minimum.
- Input stability: header_in and data_in may change freely after acceptance; only the latched copy is transmitted.

Test Plan:
- Reset idle: hold rst_in 5 cycles, then idle 20 cycles → uart_txd=1, busy_out=0, done_out=0 throughout.
- Single packet, defaults: header_in=32'hA5000008, data_in=64'h0123456789ABCDEF, valid_in 1 cycle.
  - Sampling mid-bit, the first frame reads 0,1,0,1,0,0,1,0,1,1 (byte A5).
  - The decoded byte stream is A5 00 00 08 01 23 45 67 89 AB CD EF.
  - done_out pulses 960 cycles after the first start bit begins.
- Busy rejection: 100 cycles after acceptance, pulse valid_in with data 64'hFFFF… → stream unchanged; exactly one done_out pulse.
- Back-to-back: assert valid_in in the done_out cycle with data_in=64'h0000000000000001 → second start bit appears one cycle later; the second packet's last byte is 01.
- Reset mid-packet: assert rst_in during the DATA state of byte 5 → uart_txd=1 and busy_out=0 on the next cycle, no done_out. A new packet then transmits correctly from byte 0.
- Non-default parameters: BAUD_RATE=25_000_000, giving BAUD_PERIOD=4, with MESSAGE_SIZE=16 and data_in=16'h5A3C → 6 bytes and 240 cycles total; the last two bytes are 5A 3C.
